pll_lock_ctrl: RTL and testbench



---
 rtl/pll_lock_pkg.sv | 20 ++
 rtl/sync2.sv | 22 ++
 rtl/pll_lock_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_lock_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAILED    = 3'd5
  } pll_state_e;

  // Minimum counter width able to hold values 0..n-1 (never below one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  // Capture the raw level, then re-register to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer running on the PLL reference clock.
// Holds the PLL in reset, qualifies LOCK, releases the system reset, retries
// on timeout and falls back to bypass after repeated failure.
// Optional build macro PLL_LOCK_GLITCH_FILTER_EN: lock drops in RUN must last
// GLITCH_CYCLES synced samples before they count as a loss.
module pll_lock_ctrl
  import pll_lock_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned LOSS_CNT_W          = 8
`ifdef PLL_LOCK_GLITCH_FILTER_EN
  ,
  parameter int unsigned GLITCH_CYCLES       = 4
`endif
) (
  input  logic                  REFERENCECLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  LOCK,
  output logic                  PLL_RESET_N,
  output logic                  PLL_BYPASS,
  output logic                  SYS_RESET_N,
  output logic                  LOCKED,
  output logic                  FAILED,
  output logic [STATE_W-1:0]    STATE,
  output logic [LOSS_CNT_W-1:0] LOSS_COUNT
);

  localparam int unsigned HOLD_W  = cnt_w(RESET_HOLD_CYCLES);
  localparam int unsigned TMO_W   = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int unsigned STAB_W  = cnt_w(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned RETRY_W = cnt_w(MAX_RETRIES + 1);
`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int unsigned GL_W    = cnt_w(GLITCH_CYCLES);
`endif

  pll_state_e            state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
  logic [RETRY_W-1:0]    retry_cnt_q, retry_cnt_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d, loss_inc;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
  logic [GL_W-1:0]       glitch_cnt_q, glitch_cnt_d;
  logic                  glitch_done;
`endif

  logic pll_reset_n_q, pll_reset_n_d;
  logic pll_bypass_q, pll_bypass_d;
  logic sys_reset_n_q, sys_reset_n_d;
  logic locked_q, locked_d;
  logic failed_q, failed_d;

  logic lock_s;
  logic hold_done, tmo_hit, stab_done, retry_left, lock_lost;

  // LOCK comes straight from the PLL analogue block, so it is asynchronous here.
  sync2 u_lock_sync (
    .clk   (REFERENCECLK),
    .rst_n (RESET_N),
    .d_i   (LOCK),
    .q_o   (lock_s)
  );

  assign hold_done  = (hold_cnt_q == HOLD_W'(RESET_HOLD_CYCLES - 1));
  assign tmo_hit    = (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT_CYCLES - 1));
  assign stab_done  = lock_s && (stab_cnt_q == STAB_W'(LOCK_STABLE_CYCLES));
  assign retry_left = (retry_cnt_q < RETRY_W'(MAX_RETRIES));
  // Timeout counter parks at its terminal value so it can never wrap.
  assign tmo_inc    = tmo_hit ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
  assign loss_inc   = (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + LOSS_CNT_W'(1);

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  assign glitch_done = (glitch_cnt_q == GL_W'(GLITCH_CYCLES - 1));
  assign lock_lost   = !lock_s && glitch_done;
`else
  assign lock_lost   = !lock_s;
`endif

  // Next-state, counter and output decode; outputs follow the next state so
  // the registered versions line up with the state register.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = '0;
    tmo_cnt_d   = tmo_cnt_q;
    stab_cnt_d  = stab_cnt_q;
    retry_cnt_d = retry_cnt_q;
    loss_cnt_d  = loss_cnt_q;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    glitch_cnt_d = '0;
`endif

    if (!ENABLE) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_HOLD;
          retry_cnt_d = '0;
        end
        ST_HOLD: begin
          if (hold_done) begin
            state_d   = ST_WAIT_LOCK;
            tmo_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          tmo_cnt_d = tmo_inc;
          if (lock_s) begin
            state_d    = ST_STABLE;
            stab_cnt_d = STAB_W'(1);
          end else if (tmo_hit) begin
            if (retry_left) begin
              state_d     = ST_HOLD;
              retry_cnt_d = retry_cnt_q + RETRY_W'(1);
            end else begin
              state_d = ST_FAILED;
            end
          end
        end
        ST_STABLE: begin
          tmo_cnt_d = tmo_inc;
          if (stab_done) begin
            state_d     = ST_RUN;
            retry_cnt_d = '0;
          end else if (tmo_hit) begin
            if (retry_left) begin
              state_d     = ST_HOLD;
              retry_cnt_d = retry_cnt_q + RETRY_W'(1);
            end else begin
              state_d = ST_FAILED;
            end
          end else if (!lock_s) begin
            state_d    = ST_WAIT_LOCK;
            stab_cnt_d = '0;
          end else begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
          end
        end
        ST_RUN: begin
          if (lock_lost) begin
            state_d    = ST_HOLD;
            loss_cnt_d = loss_inc;
          end
`ifdef PLL_LOCK_GLITCH_FILTER_EN
          else if (!lock_s) begin
            glitch_cnt_d = glitch_cnt_q + GL_W'(1);
          end
`endif
        end
        ST_FAILED: begin
          state_d = ST_FAILED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    pll_reset_n_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                    (state_d == ST_RUN);
    pll_bypass_d  = (state_d == ST_FAILED);
    sys_reset_n_d = (state_d == ST_RUN) || (state_d == ST_FAILED);
    locked_d      = (state_d == ST_RUN);
    failed_d      = (state_d == ST_FAILED);
  end

  // State, counters and registered outputs.
  always_ff @(posedge REFERENCECLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      stab_cnt_q    <= '0;
      retry_cnt_q   <= '0;
      loss_cnt_q    <= '0;
      pll_reset_n_q <= 1'b0;
      pll_bypass_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      locked_q      <= 1'b0;
      failed_q      <= 1'b0;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
      glitch_cnt_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      stab_cnt_q    <= stab_cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
      pll_reset_n_q <= pll_reset_n_d;
      pll_bypass_q  <= pll_bypass_d;
      sys_reset_n_q <= sys_reset_n_d;
      locked_q      <= locked_d;
      failed_q      <= failed_d;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
      glitch_cnt_q  <= glitch_cnt_d;
`endif
    end
  end

  assign PLL_RESET_N = pll_reset_n_q;
  assign PLL_BYPASS  = pll_bypass_q;
  assign SYS_RESET_N = sys_reset_n_q;
  assign LOCKED      = locked_q;
  assign FAILED      = failed_q;
  assign STATE       = state_q;
  assign LOSS_COUNT  = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: hold 4, stable 8, timeout 32, 2 retries,
// 2-bit loss counter. Honours PLL_LOCK_GLITCH_FILTER_EN when defined.
module tb_pll_lock_ctrl;

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int DROP = 4;
`else
  localparam int DROP = 1;
`endif

  logic       clk = 1'b0;
  logic       RESET_N, ENABLE, LOCK;
  logic       PLL_RESET_N, PLL_BYPASS, SYS_RESET_N, LOCKED, FAILED;
  logic [2:0] STATE;
  logic [1:0] LOSS_COUNT;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pll_lock_ctrl #(
    .RESET_HOLD_CYCLES   (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2),
    .LOSS_CNT_W          (2)
  ) dut (
    .REFERENCECLK (clk),
    .RESET_N      (RESET_N),
    .ENABLE       (ENABLE),
    .LOCK         (LOCK),
    .PLL_RESET_N  (PLL_RESET_N),
    .PLL_BYPASS   (PLL_BYPASS),
    .SYS_RESET_N  (SYS_RESET_N),
    .LOCKED       (LOCKED),
    .FAILED       (FAILED),
    .STATE        (STATE),
    .LOSS_COUNT   (LOSS_COUNT)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (STATE !== s && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 16'(STATE), 16'(s));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 16'(STATE), 16'd0);
    chk({tag, "_pll_rst"}, 16'(PLL_RESET_N), 16'd0);
    chk({tag, "_bypass"}, 16'(PLL_BYPASS), 16'd0);
    chk({tag, "_sys_rst"}, 16'(SYS_RESET_N), 16'd0);
    chk({tag, "_locked"}, 16'(LOCKED), 16'd0);
    chk({tag, "_failed"}, 16'(FAILED), 16'd0);
    chk({tag, "_loss"}, 16'(LOSS_COUNT), 16'd0);
  endtask

  initial begin
    int         hold_cycles;
    int         hold_entries;
    logic [2:0] prev;

    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    LOCK    = 1'b0;
    #2;
    chk_reset_outputs("por");

    tick(2);
    RESET_N = 1'b1;
    tick(2);
    chk("idle_no_enable", 16'(STATE), 16'd0);

    // Nominal bring-up.
    ENABLE = 1'b1;
    tick(1);
    chk("nom_hold_state", 16'(STATE), 16'd1);
    chk("nom_hold_pllrst", 16'(PLL_RESET_N), 16'd0);
    tick(3);
    chk("nom_hold_4th", 16'(PLL_RESET_N), 16'd0);
    tick(1);
    chk("nom_release", 16'(PLL_RESET_N), 16'd1);
    chk("nom_wait_state", 16'(STATE), 16'd2);
    tick(10);
    LOCK = 1'b1;
    tick(10);
    chk("nom_sys_rst_edge10", 16'(SYS_RESET_N), 16'd0);
    chk("nom_stable_edge10", 16'(STATE), 16'd3);
    tick(1);
    chk("nom_sys_rst_edge11", 16'(SYS_RESET_N), 16'd1);
    chk("nom_locked", 16'(LOCKED), 16'd1);
    chk("nom_run_state", 16'(STATE), 16'd4);
    chk("nom_bypass", 16'(PLL_BYPASS), 16'd0);
    chk("nom_loss0", 16'(LOSS_COUNT), 16'd0);

    // Lock loss in RUN.
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    LOCK = 1'b0;
    tick(1);
    LOCK = 1'b1;
    tick(6);
    chk("glitch_ignored_state", 16'(STATE), 16'd4);
    chk("glitch_ignored_loss", 16'(LOSS_COUNT), 16'd0);
    LOCK = 1'b0;
    tick(4);
    LOCK = 1'b1;
    tick(1);
    chk("loss_sys_rst_edge5", 16'(SYS_RESET_N), 16'd1);
    tick(1);
`else
    LOCK = 1'b0;
    tick(1);
    LOCK = 1'b1;
    tick(1);
    chk("loss_sys_rst_edge2", 16'(SYS_RESET_N), 16'd1);
    tick(1);
`endif
    chk("loss_sys_rst_low", 16'(SYS_RESET_N), 16'd0);
    chk("loss_state_hold", 16'(STATE), 16'd1);
    chk("loss_locked_low", 16'(LOCKED), 16'd0);
    chk("loss_count1", 16'(LOSS_COUNT), 16'd1);
    wait_state(3'd4, 40, "relock1");

    // Saturating loss counter: four more losses on a 2-bit counter.
    for (int k = 2; k <= 5; k++) begin
      LOCK = 1'b0;
      tick(DROP);
      LOCK = 1'b1;
      wait_state(3'd1, 20, "sat_loss_seen");
      wait_state(3'd4, 40, "sat_relock");
      chk("sat_loss_count", 16'(LOSS_COUNT), (k > 3) ? 16'd3 : 16'(k));
    end

    // Async reset in RUN.
    RESET_N = 1'b0;
    #1;
    chk_reset_outputs("arst_run");
    tick(1);
    RESET_N = 1'b1;
    tick(1);
    chk("arst_run_restart", 16'(STATE), 16'd1);

    // Async reset in STABLE.
    wait_state(3'd3, 20, "reach_stable");
    RESET_N = 1'b0;
    #1;
    chk("arst_stable_state", 16'(STATE), 16'd0);
    chk("arst_stable_pllrst", 16'(PLL_RESET_N), 16'd0);
    chk("arst_stable_sysrst", 16'(SYS_RESET_N), 16'd0);
    tick(1);
    RESET_N = 1'b1;
    tick(1);
    chk("arst_stable_restart", 16'(STATE), 16'd1);

    // ENABLE low wins from HOLD.
    LOCK   = 1'b0;
    ENABLE = 1'b0;
    tick(1);
    chk("disable_to_idle", 16'(STATE), 16'd0);
    tick(3);

    // Never locks: three attempts then FAILED at edge 109.
    hold_cycles  = 0;
    hold_entries = 0;
    prev         = STATE;
    ENABLE       = 1'b1;
    for (int i = 0; i < 108; i++) begin
      tick(1);
      if (STATE == 3'd1 && PLL_RESET_N == 1'b0) hold_cycles++;
      if (STATE == 3'd1 && prev != 3'd1) hold_entries++;
      prev = STATE;
    end
    chk("fail_pre_state", 16'(STATE), 16'd2);
    chk("fail_hold_cycles", 16'(hold_cycles), 16'd12);
    chk("fail_hold_entries", 16'(hold_entries), 16'd3);
    tick(1);
    chk("fail_state", 16'(STATE), 16'd5);
    chk("fail_flag", 16'(FAILED), 16'd1);
    chk("fail_bypass", 16'(PLL_BYPASS), 16'd1);
    chk("fail_sys_rst", 16'(SYS_RESET_N), 16'd1);
    chk("fail_pll_rst", 16'(PLL_RESET_N), 16'd0);
    chk("fail_locked", 16'(LOCKED), 16'd0);
    tick(5);
    chk("fail_sticky", 16'(STATE), 16'd5);
    ENABLE = 1'b0;
    tick(1);
    chk("fail_exit_state", 16'(STATE), 16'd0);
    chk("fail_exit_flag", 16'(FAILED), 16'd0);
    chk("fail_exit_bypass", 16'(PLL_BYPASS), 16'd0);
    chk("fail_exit_sys_rst", 16'(SYS_RESET_N), 16'd0);

    // Lock chatter: 5 high, 2 low, then high for good.
    ENABLE = 1'b1;
    tick(1);
    chk("chat_hold", 16'(STATE), 16'd1);
    tick(4);
    chk("chat_wait", 16'(STATE), 16'd2);
    tick(1);
    LOCK = 1'b1;
    tick(5);
    LOCK = 1'b0;
    tick(2);
    LOCK = 1'b1;
    tick(1);
    chk("chat_back_to_wait", 16'(STATE), 16'd2);
    tick(9);
    chk("chat_stable_edge10", 16'(STATE), 16'd3);
    chk("chat_sys_rst_edge10", 16'(SYS_RESET_N), 16'd0);
    tick(1);
    chk("chat_run_edge11", 16'(STATE), 16'd4);
    chk("chat_sys_rst_edge11", 16'(SYS_RESET_N), 16'd1);
    chk("chat_locked", 16'(LOCKED), 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
